// File: rtl/lcd_frame_feeder_pkg.sv
// lcd_frame_feeder_pkg: feeder state encoding and download-queue marker words shared with the downloader
package lcd_frame_feeder_pkg;

    typedef enum logic [1:0] {IDLE, SEEK_FRAME, WAIT_LINE, STREAM} t_state;

    localparam logic [16:0] MK_FRAME = 17'h10000;
    localparam logic [16:0] MK_ROW   = 17'h10001;
    localparam logic [16:0] MK_END   = 17'h1FFFF;

endpackage

// File: rtl/lcd_frame_feeder.sv
// lcd_frame_feeder: pops markers/pixels from the download FIFO and aligns them to the LCD strobes
//   clk, reset_n                           clock, asynchronous active-low reset
//   queue_data_i, queue_empty, queue_rd_en FWFT FIFO head (bit16 = marker), empty flag, pop
//   lcd_frame_start, lcd_line_start        LCD vertical / line start pulses
//   lcd_pixel_req                          pixel strobe, at most one per clk
//   pixel_data, pixel_valid                registered pixel, one clk after each strobe
//   frame_rq                               one-clk start request to the downloader
//   underflow, sync_err                    sticky error flags, cleared on lcd_frame_start
module lcd_frame_feeder
    import lcd_frame_feeder_pkg::*;
#(
    parameter int          FRAME_WIDTH  = 480,
    parameter int          FRAME_HEIGHT = 272,
    parameter logic [15:0] FILL_COLOR   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [16:0] queue_data_i,
    input  logic        queue_empty,
    output logic        queue_rd_en,
    input  logic        lcd_frame_start,
    input  logic        lcd_line_start,
    input  logic        lcd_pixel_req,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_rq,
    output logic        underflow,
    output logic        sync_err
);

    t_state      state;
    logic [10:0] col;
    logic [9:0]  row;
    logic        fill_only;
    logic        is_pix;
    logic        at_end;
    logic        last_col;
    logic        serve;

    // WAIT_LINE discards stray pixels while waiting; after the last row it only hunts for MK_END
    always_comb begin
        is_pix      = !queue_data_i[16];
        at_end      = row == 10'(FRAME_HEIGHT);
        last_col    = col == 11'(FRAME_WIDTH - 1);
        serve       = state == STREAM && lcd_pixel_req && !queue_empty && is_pix && !fill_only;
        queue_rd_en = serve || (!queue_empty && (state == SEEK_FRAME ||
                      (state == WAIT_LINE && (at_end ? (is_pix || queue_data_i == MK_END) :
                                             lcd_line_start ? queue_data_i == MK_ROW : is_pix))));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            fill_only   <= 1'b0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_rq    <= 1'b0;
            underflow   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_rq    <= lcd_frame_start;
            pixel_valid <= lcd_pixel_req;
            if (lcd_pixel_req)
                pixel_data <= serve ? queue_data_i[15:0] : FILL_COLOR;
            if (lcd_frame_start) begin
                state     <= SEEK_FRAME;
                col       <= '0;
                row       <= '0;
                fill_only <= 1'b0;
                underflow <= 1'b0;
                // a finished frame still parked in WAIT_LINE never saw its MK_END
                sync_err  <= state == WAIT_LINE && at_end;
            end else begin
                case (state)
                    SEEK_FRAME:
                        if (queue_rd_en && queue_data_i == MK_FRAME) begin
                            state <= WAIT_LINE;
                            row   <= '0;
                        end
                    WAIT_LINE:
                        if (at_end) begin
                            if (queue_rd_en && queue_data_i == MK_END)
                                state <= IDLE;
                            if (queue_rd_en && is_pix)
                                sync_err <= 1'b1;
                        end else if (lcd_line_start) begin
                            col       <= '0;
                            state     <= STREAM;
                            fill_only <= !queue_rd_en;
                            if (!queue_rd_en)
                                sync_err <= 1'b1;
                        end else if (queue_rd_en) begin
                            sync_err <= 1'b1;
                        end
                    STREAM:
                        if (lcd_pixel_req) begin
                            if (queue_empty)
                                underflow <= 1'b1;
                            else if (!is_pix)
                                sync_err <= 1'b1;
                            col <= last_col ? '0 : col + 11'd1;
                            if (last_col) begin
                                row   <= row + 10'd1;
                                state <= WAIT_LINE;
                            end
                        end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// tb_lcd_frame_feeder: randomized scoreboard bench for lcd_frame_feeder on a reduced frame geometry
module tb_lcd_frame_feeder;

    localparam int          W    = 32;
    localparam int          H    = 8;
    localparam logic [15:0] FILL = 16'hF81F;
    localparam logic [16:0] K_FRAME = 17'h10000;
    localparam logic [16:0] K_ROW   = 17'h10001;
    localparam logic [16:0] K_END   = 17'h1FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] queue_data_i;
    logic        queue_empty;
    logic        queue_rd_en;
    logic        lcd_frame_start;
    logic        lcd_line_start;
    logic        lcd_pixel_req;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_rq;
    logic        underflow;
    logic        sync_err;

    lcd_frame_feeder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FILL_COLOR(FILL)) dut (
        .clk(clk), .reset_n(reset_n), .queue_data_i(queue_data_i), .queue_empty(queue_empty),
        .queue_rd_en(queue_rd_en), .lcd_frame_start(lcd_frame_start), .lcd_line_start(lcd_line_start),
        .lcd_pixel_req(lcd_pixel_req), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .frame_rq(frame_rq), .underflow(underflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          fs_count = 0;
    int          rq_count = 0;
    logic [16:0] fifo[$];
    logic [15:0] rowbuf[$];
    int          rowlen[$];
    logic [15:0] exp_q[$];
    logic        req_prev = 1'b0;
    logic        fs_prev = 1'b0;
    int          size0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        queue_empty  = fifo.size() == 0;
        queue_data_i = fifo.size() != 0 ? fifo[0] : 17'h0;
    endtask

    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = queue_rd_en;
        @(posedge clk);
        #1;
        if (pop) begin
            chk("rd_en_nonempty", 32'(fifo.size() != 0), 1);
            if (fifo.size() != 0)
                void'(fifo.pop_front());
        end
        refresh();
    endtask

    task automatic cycle(input logic fs, input logic ls, input logic pr);
        lcd_frame_start = fs;
        lcd_line_start  = ls;
        lcd_pixel_req   = pr;
        if (fs)
            fs_count++;
        tick();
        lcd_frame_start = 1'b0;
        lcd_line_start  = 1'b0;
        lcd_pixel_req   = 1'b0;
    endtask

    task automatic push(input logic [16:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic load_row(input int n, input bit ramp);
        logic [15:0] v;
        push(K_ROW);
        rowlen.push_back(n);
        for (int i = 0; i < n; i++) begin
            v = ramp ? 16'(i) : 16'($urandom);
            push({1'b0, v});
            rowbuf.push_back(v);
        end
    endtask

    task automatic load_frame(input bit ramp, input int short_row, input int short_n);
        push(K_FRAME);
        for (int r = 0; r < H; r++)
            load_row(r == short_row ? short_n : W, ramp);
        push(K_END);
    endtask

    task automatic start_frame(input int lead);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (lead) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // expected pixel for column c of a row that was loaded with n words: the word, or fill once the row ran short
    task automatic show_line(input int ncols, input bit fs_last);
        int          n;
        logic [15:0] p[$];
        n = rowlen.pop_front();
        for (int i = 0; i < n; i++)
            p.push_back(rowbuf.pop_front());
        cycle(1'b0, 1'b1, 1'b0);
        repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < ncols; c++) begin
            repeat ($urandom_range(0, 1)) cycle(1'b0, 1'b0, 1'b0);
            exp_q.push_back(c < n ? p[c] : FILL);
            cycle(fs_last && c == ncols - 1, 1'b0, 1'b1);
        end
        repeat (30) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_model();
        rowlen.delete();
        rowbuf.delete();
    endtask

    task automatic chk_flags(input string tag, input logic uf, input logic se);
        chk({tag, "_underflow"}, 32'(underflow), 32'(uf));
        chk({tag, "_sync_err"}, 32'(sync_err), 32'(se));
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            req_prev = 1'b0;
            fs_prev  = 1'b0;
        end else begin
            if (pixel_valid || req_prev)
                chk("pixel_valid", 32'(pixel_valid), 32'(req_prev));
            if (pixel_valid && req_prev) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_empty: got pixel %0h expected none queued", pixel_data);
                end else begin
                    chk("pixel_data", 32'(pixel_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_rq || fs_prev)
                chk("frame_rq", 32'(frame_rq), 32'(fs_prev));
            if (frame_rq)
                rq_count++;
            req_prev = lcd_pixel_req;
            fs_prev  = lcd_frame_start;
        end
    end

    initial begin
        reset_n = 1'b0;
        lcd_frame_start = 1'b0;
        lcd_line_start  = 1'b0;
        lcd_pixel_req   = 1'b0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel_data", 32'(pixel_data), 0);
        chk("rst_pixel_valid", 32'(pixel_valid), 0);
        chk("rst_frame_rq", 32'(frame_rq), 0);
        chk("rst_rd_en", 32'(queue_rd_en), 0);
        chk_flags("rst", 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // full ramp frame, then the feeder must sit in IDLE without popping
        load_frame(1'b1, -1, 0);
        start_frame(10);
        for (int r = 0; r < H; r++)
            show_line(W, 1'b0);
        chk_flags("t1", 1'b0, 1'b0);
        repeat (4) push({1'b0, 16'($urandom)});
        size0 = fifo.size();
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        chk("t1_idle_no_pop", fifo.size(), size0);

        // underflow: row 0 holds only 10 pixels, rest of the frame arrives before line 1
        push(K_FRAME);
        load_row(10, 1'b0);
        start_frame(10);
        show_line(W, 1'b0);
        chk_flags("t2_row0", 1'b1, 1'b0);
        for (int r = 1; r < H; r++)
            load_row(W, 1'b0);
        push(K_END);
        for (int r = 1; r < H; r++)
            show_line(W, 1'b0);
        chk_flags("t2_end", 1'b1, 1'b0);

        // short row: MK_ROW must stay put until line 1 starts
        load_frame(1'b0, 0, 20);
        start_frame(10);
        chk_flags("t3_cleared", 1'b0, 1'b0);
        show_line(W, 1'b0);
        chk_flags("t3_row0", 1'b0, 1'b1);
        for (int r = 1; r < H; r++)
            show_line(W, 1'b0);
        chk_flags("t3_end", 1'b0, 1'b1);

        // long row: six extra pixels discarded between lines
        load_frame(1'b0, 0, W + 6);
        start_frame(10);
        chk_flags("t4_cleared", 1'b0, 1'b0);
        for (int r = 0; r < H; r++)
            show_line(W, 1'b0);
        chk_flags("t4_end", 1'b0, 1'b1);

        // mid-frame resync on row 5 coinciding with a pixel pop, stale data flushed
        load_frame(1'b0, 1, 10);
        start_frame(10);
        for (int r = 0; r < 5; r++)
            show_line(W, 1'b0);
        chk_flags("t5_before", 1'b0, 1'b1);
        show_line(5, 1'b1);
        chk_flags("t5_cleared", 1'b0, 1'b0);
        clear_model();
        load_frame(1'b0, -1, 0);
        repeat (200) cycle(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < H; r++)
            show_line(W, 1'b0);
        chk_flags("t5_end", 1'b0, 1'b0);

        // asynchronous reset in the middle of a streaming line
        load_frame(1'b0, 0, 10);
        start_frame(10);
        show_line(W, 1'b0);
        show_line(W, 1'b0);
        show_line(3, 1'b0);
        chk("t6_pre_sync_err", 32'(sync_err), 1);
        lcd_pixel_req = 1'b1;
        #1;
        chk("t6_pre_rd_en", 32'(queue_rd_en), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rd_en", 32'(queue_rd_en), 0);
        chk("t6_pixel_data", 32'(pixel_data), 0);
        chk("t6_pixel_valid", 32'(pixel_valid), 0);
        chk("t6_frame_rq", 32'(frame_rq), 0);
        chk_flags("t6_rst", 1'b0, 1'b0);
        lcd_pixel_req = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        clear_model();
        size0 = fifo.size();
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        chk("t6_idle_no_pop", fifo.size(), size0);
        load_frame(1'b1, -1, 0);
        start_frame(200);
        for (int r = 0; r < H; r++)
            show_line(W, 1'b0);
        chk_flags("t6_end", 1'b0, 1'b0);

        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("sb_drained", exp_q.size(), 0);
        chk("frame_rq_count", rq_count, fs_count);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
